mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared constants and FSM encoding for the MEM stage
// Contents: control_in bit positions, IDLE/BUSY state encoding, watchdog limit.
package mem_access_unit_pkg;

  localparam int CTL_MEM_READ   = 0;
  localparam int CTL_MEM_WRITE  = 1;
  localparam int CTL_BYTE       = 2;
  localparam int CTL_REG_WRITE  = 3;
  localparam int CTL_MEM_TO_REG = 4;
  localparam int CTL_BRANCH     = 5;

  // Number of BUSY cycles without ack after which the transfer is abandoned.
  localparam logic [7:0] WDOG_LIMIT = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/ack bus
// Signals: mem_req, mem_we, mem_addr, mem_wdata, mem_be (unit -> memory);
//          mem_rdata, mem_ack (memory -> unit).
// Modports: master (the access unit), slave (the memory).
interface mem_access_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and loads
// Ports:
//   byte_access  in   1  1 = byte access, 0 = word access
//   lane         in   2  byte lane (address bits [1:0])
//   store_data   in  32  raw store data
//   rdata        in  32  raw memory read data
//   wdata        out 32  lane-aligned store data
//   be           out  4  byte enables
//   load_data    out 32  extracted, zero-extended load data
module mem_lane_align (
  input  logic        byte_access,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = rdata[7:0];
    case (lane)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
  end

  always_comb begin
    wdata     = store_data;
    be        = 4'b1111;
    load_data = rdata;
    if (byte_access) begin
      // Replicating the byte lets the memory pick it up on whichever lane is enabled.
      wdata     = {4{store_data[7:0]}};
      be        = 4'b0001 << lane;
      load_data = {24'd0, sel_byte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage: memory handshake, stall, watchdog, M/WB register
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   address_in        ALU result (memory address or ALU value)
//   next_pc_in        branch target (routed externally, not used here)
//   ALU_zero_in       ALU zero flag
//   data_in           store data
//   control_in        [0] mem_read [1] mem_write [2] byte [3] reg_write [4] mem_to_reg [5] branch
//   rgD_index_in      destination register index
//   mem               memory bus (master side)
//   stall             holds EX/M and earlier stages
//   wb_valid/wb_data/wb_rd/wb_reg_write  registered M/WB fields, wb_valid is a 1-cycle pulse
//   pc_src            branch taken
//   mem_err           1-cycle pulse on misaligned access or watchdog timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic [31:0] next_pc_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] data_in,
  input  logic [5:0]  control_in,
  input  logic [4:0]  rgD_index_in,
  mem_access_unit_if.master mem,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        pc_src,
  output logic        mem_err
);

  state_t      state;
  logic [7:0]  wdog_cnt;

  // Request fields captured at issue; EX/M is frozen while BUSY but these
  // keep the writeback independent of what the upstream register holds.
  logic        lat_byte;
  logic [1:0]  lat_lane;
  logic        lat_load;
  logic [31:0] lat_addr;
  logic        lat_reg_write;
  logic [4:0]  lat_rd;

  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic        busy;
  logic        timeout;

  logic        align_byte;
  logic [1:0]  align_lane;
  logic [31:0] align_wdata;
  logic [3:0]  align_be;
  logic [31:0] align_load;

  logic        unused_inputs;
  assign unused_inputs = ^{next_pc_in, control_in[CTL_MEM_TO_REG]};

  assign mem_op     = control_in[CTL_MEM_READ] | control_in[CTL_MEM_WRITE];
  assign misaligned = mem_op && !control_in[CTL_BYTE] && (address_in[1:0] != 2'b00);
  assign busy       = (state == ST_BUSY);
  assign issue      = (state == ST_IDLE) && mem_op && !misaligned;
  // wdog_cnt holds the number of BUSY cycles already spent, so this is the 255th one.
  assign timeout    = busy && !mem.mem_ack && (wdog_cnt == WDOG_LIMIT - 8'd1);

  // Stall releases in the completing cycle so EX/M loads the next op at the same edge
  // the FSM returns to IDLE. Gated by reset so a held mem op cannot stall during reset.
  assign stall  = !reset && (issue || (busy && !mem.mem_ack && !timeout));
  assign pc_src = !reset && !stall && control_in[CTL_BRANCH] && ALU_zero_in;

  // Issue-time steering comes from the live inputs, completion-time from the latch.
  assign align_byte = busy ? lat_byte : control_in[CTL_BYTE];
  assign align_lane = busy ? lat_lane : address_in[1:0];

  mem_lane_align u_lane_align (
    .byte_access (align_byte),
    .lane        (align_lane),
    .store_data  (data_in),
    .rdata       (mem.mem_rdata),
    .wdata       (align_wdata),
    .be          (align_be),
    .load_data   (align_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wdog_cnt      <= 8'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      mem.mem_be    <= 4'b0000;
      wb_valid      <= 1'b0;
      wb_data       <= 32'd0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      mem_err       <= 1'b0;
      lat_byte      <= 1'b0;
      lat_lane      <= 2'd0;
      lat_load      <= 1'b0;
      lat_addr      <= 32'd0;
      lat_reg_write <= 1'b0;
      lat_rd        <= 5'd0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state         <= ST_BUSY;
            wdog_cnt      <= 8'd0;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= control_in[CTL_MEM_WRITE];
            mem.mem_addr  <= {address_in[31:2], 2'b00};
            mem.mem_wdata <= control_in[CTL_MEM_WRITE] ? align_wdata : 32'd0;
            mem.mem_be    <= align_be;
            lat_byte      <= control_in[CTL_BYTE];
            lat_lane      <= address_in[1:0];
            lat_load      <= !control_in[CTL_MEM_WRITE];
            lat_addr      <= address_in;
            lat_reg_write <= control_in[CTL_REG_WRITE];
            lat_rd        <= rgD_index_in;
          end else if (misaligned) begin
            wb_valid     <= 1'b1;
            mem_err      <= 1'b1;
            wb_data      <= address_in;
            wb_rd        <= rgD_index_in;
            wb_reg_write <= 1'b0;
          end else if (control_in != 6'd0) begin
            wb_valid     <= 1'b1;
            wb_data      <= address_in;
            wb_rd        <= rgD_index_in;
            wb_reg_write <= control_in[CTL_REG_WRITE];
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack) begin
            state        <= ST_IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 4'b0000;
            wb_valid     <= 1'b1;
            wb_data      <= lat_load ? align_load : lat_addr;
            wb_rd        <= lat_rd;
            wb_reg_write <= lat_reg_write;
          end else if (timeout) begin
            state        <= ST_IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 4'b0000;
            mem_err      <= 1'b1;
            wb_valid     <= 1'b1;
            wb_data      <= lat_addr;
            wb_rd        <= lat_rd;
            wb_reg_write <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic [31:0] next_pc_in;
  logic        ALU_zero_in;
  logic [31:0] data_in;
  logic [5:0]  control_in;
  logic [4:0]  rgD_index_in;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        pc_src;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .address_in   (address_in),
    .next_pc_in   (next_pc_in),
    .ALU_zero_in  (ALU_zero_in),
    .data_in      (data_in),
    .control_in   (control_in),
    .rgD_index_in (rgD_index_in),
    .mem          (bus),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .pc_src       (pc_src),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Writeback value from the architectural rules: loads return the addressed
  // byte (zero-extended) or the whole word, everything else returns the ALU value.
  function automatic logic [31:0] model_wb_data(input logic [5:0] ctl, input logic [31:0] addr,
                                                input logic [31:0] rdata);
    logic [31:0] shifted;
    if (ctl[0] && !ctl[1]) begin
      if (ctl[2]) begin
        shifted = rdata >> (8 * addr[1:0]);
        return shifted & 32'h0000_00FF;
      end
      return rdata;
    end
    return addr;
  endfunction

  // One instruction through the stage: waits = BUSY cycles without ack before
  // the ack cycle; waits >= 255 means the memory never answers.
  task automatic do_op(input logic [5:0] ctl, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic zero, input int waits,
                       input logic [31:0] rdata);
    logic       memop, is_byte, is_store, mis, tmo, good;
    logic [3:0] be_exp;
    int         stall_cnt, busy_max;
    memop    = ctl[0] | ctl[1];
    is_byte  = ctl[2];
    is_store = ctl[1];
    mis      = memop && !is_byte && (addr[1:0] != 2'b00);
    tmo      = memop && !mis && (waits >= 255);
    be_exp   = 4'b0001;
    be_exp   = is_byte ? (be_exp << addr[1:0]) : 4'b1111;

    @(negedge clk);
    control_in   = ctl;
    address_in   = addr;
    data_in      = data;
    rgD_index_in = rd;
    ALU_zero_in  = zero;
    next_pc_in   = $urandom;
    bus.mem_ack  = 1'b0;
    #1;
    chk("issue_stall", 32'(stall), 32'(memop && !mis));
    chk("issue_pc_src", 32'(pc_src), 32'((memop && !mis) ? 1'b0 : (ctl[5] & zero)));
    chk("issue_req", 32'(bus.mem_req), 32'd0);
    stall_cnt = int'(stall);

    if (memop && !mis) begin
      busy_max = tmo ? 255 : waits + 1;
      for (int b = 1; b <= busy_max; b++) begin
        @(negedge clk);
        if (b == waits + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end else begin
          bus.mem_rdata = $urandom;
        end
        #1;
        chk("busy_req", 32'(bus.mem_req), 32'd1);
        chk("busy_addr", bus.mem_addr, {addr[31:2], 2'b00});
        chk("busy_we", 32'(bus.mem_we), 32'(is_store));
        chk("busy_be", 32'(bus.mem_be), 32'(be_exp));
        if (is_store) chk("busy_wdata", bus.mem_wdata, is_byte ? {4{data[7:0]}} : data);
        chk("busy_pc_src", 32'(pc_src), 32'd0);
        stall_cnt += int'(stall);
      end
      if (!tmo) chk("stall_cycles", stall_cnt, waits + 1);
    end

    @(negedge clk);
    control_in  = 6'd0;
    bus.mem_ack = 1'b0;
    #1;
    good = !mis && !tmo;
    if (ctl == 6'd0) begin
      chk("bubble_wb_valid", 32'(wb_valid), 32'd0);
    end else begin
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("mem_err", 32'(mem_err), 32'(!good));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(good ? ctl[3] : 1'b0));
      chk("wb_req_low", 32'(bus.mem_req), 32'd0);
      if (good) begin
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_data", wb_data, model_wb_data(ctl, addr, rdata));
      end
    end
    @(negedge clk);
    #1;
    chk("pulse_wb_valid", 32'(wb_valid), 32'd0);
    chk("pulse_mem_err", 32'(mem_err), 32'd0);
  endtask

  initial begin
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic        bsel;

    reset         = 1'b1;
    control_in    = 6'b000001;
    address_in    = 32'h0000_0100;
    data_in       = 32'd0;
    rgD_index_in  = 5'd0;
    ALU_zero_in   = 1'b1;
    next_pc_in    = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;

    // Reset state, with a memory op presented that must not stall.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    @(negedge clk);
    control_in = 6'd0;
    reset      = 1'b0;

    // ack while IDLE is ignored
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_ack_req", 32'(bus.mem_req), 32'd0);

    // Directed scenarios
    do_op(6'b011001, 32'h0000_0100, 32'd0, 5'd5, 1'b0, 3, 32'hDEAD_BEEF);   // word load, 4 stall cycles
    do_op(6'b000110, 32'h0000_0203, 32'h0000_00A5, 5'd0, 1'b0, 0, 32'd0);   // byte store lane 3
    do_op(6'b011101, 32'h0000_0202, 32'd0, 5'd9, 1'b0, 1, 32'h1122_3344);   // byte load -> 0x22
    do_op(6'b011001, 32'h0000_0101, 32'd0, 5'd4, 1'b0, 0, 32'd0);           // misaligned word load
    do_op(6'b000010, 32'h0000_0400, 32'hCAFE_F00D, 5'd0, 1'b0, 2, 32'd0);   // word store
    do_op(6'b011001, 32'h0000_0500, 32'd0, 5'd3, 1'b0, 255, 32'd0);         // watchdog timeout
    do_op(6'b011001, 32'h0000_0600, 32'd0, 5'd6, 1'b0, 254, 32'h0BAD_F00D); // ack on cycle 255 wins
    do_op(6'b100000, 32'h0000_0040, 32'd0, 5'd0, 1'b1, 0, 32'd0);           // taken branch
    do_op(6'b001000, 32'h7777_8888, 32'd0, 5'd12, 1'b1, 0, 32'd0);          // ALU op

    // Randomized mix against the reference model
    for (int i = 0; i < 40; i++) begin
      bsel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ctl = 6'd0;
        1:       ctl = {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 3'b000};
        2:       ctl = {1'b0, 1'b1, 1'b1, bsel, 1'b0, 1'b1};
        default: ctl = {1'b0, 1'b0, 1'($urandom_range(0, 1)), bsel, 1'b1, 1'b0};
      endcase
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      do_op(ctl, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 4)), $urandom);
    end

    // Reset in the middle of a BUSY transfer
    @(negedge clk);
    control_in   = 6'b011001;
    address_in   = 32'h0000_0300;
    rgD_index_in = 5'd7;
    ALU_zero_in  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_busy_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_be", 32'(bus.mem_be), 32'd0);
    chk("midrst_addr", bus.mem_addr, 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_pc_src", 32'(pc_src), 32'd0);
    @(negedge clk);
    control_in = 6'd0;
    reset      = 1'b0;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("late_ack_wb_valid2", 32'(wb_valid), 32'd0);
    chk("late_ack_req", 32'(bus.mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
